// File: rtl/tff_updown_counter_pkg.sv
// Shared defaults for the lab-board BCD event counter (one decade, 0..9).
package tff_updown_counter_pkg;

    localparam int DEFAULT_WIDTH   = 4;
    localparam int DEFAULT_MODULUS = 10;

endpackage : tff_updown_counter_pkg

// File: rtl/tff_updown_counter_tff_cell.sv
// Single-bit T flip-flop. Q inverts on a rising clock edge when T is high.
// Q clears asynchronously while rst_ni is low.
module tff_cell (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic t_i,
    output logic q_o
);

    logic q_q;

    // Toggle storage: invert on T, clear on async reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= 1'b0;
        end else if (t_i) begin
            q_q <= ~q_q;
        end
    end

    assign q_o = q_q;

endmodule : tff_cell

// File: rtl/tff_updown_counter.sv
// Modulo-MODULUS up/down counter built from T cells.
// The next count is computed in binary. The T input of each cell is the XOR
// of its current Q with the next-state bit, so only the bits that change
// toggle. wrap and clamp are one-cycle registered pulses that line up with
// the new count.
module tff_updown_counter
    import tff_updown_counter_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int MODULUS = DEFAULT_MODULUS
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             clamp
);

    // MAX is also kept one bit wider. Range checks then stay meaningful when
    // MAX is the all-ones value, as it is for MODULUS = 2**WIDTH.
    localparam logic [WIDTH:0]   MAX_X = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] MAX   = MAX_X[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_param
        $error("tff_updown_counter: MODULUS out of range for WIDTH");
    end

    logic [WIDTH:0]   count_x;
    logic [WIDTH:0]   din_x;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] toggle;
    logic             wrap_d;
    logic             wrap_q;
    logic             clamp_d;
    logic             clamp_q;

    assign count_x = {1'b0, count};
    assign din_x   = {1'b0, din};

    // Next-state select: load beats count enable, and up picks the direction.
    // An out-of-range state recovers to 0 when counting up and to MAX when
    // counting down. Both recoveries are reported as a wrap.
    always_comb begin
        count_d = count;
        wrap_d  = 1'b0;
        clamp_d = 1'b0;
        if (load) begin
            if (din_x > MAX_X) begin
                count_d = MAX;
                clamp_d = 1'b1;
            end else begin
                count_d = din;
            end
        end else if (en) begin
            if (up) begin
                if (count_x >= MAX_X) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count + ONE;
                end
            end else begin
                if (count == '0 || count_x > MAX_X) begin
                    count_d = MAX;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count - ONE;
                end
            end
        end
    end

    assign toggle = count ^ count_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        tff_cell u_cell (
            .clk_i  (clock),
            .rst_ni (reset),
            .t_i    (toggle[i]),
            .q_o    (count[i])
        );
    end

    // Event pulses: registered so they are aligned with the updated count
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wrap_q  <= 1'b0;
            clamp_q <= 1'b0;
        end else begin
            wrap_q  <= wrap_d;
            clamp_q <= clamp_d;
        end
    end

    assign wrap  = wrap_q;
    assign clamp = clamp_q;

    // Terminal count is not qualified by en. Cascade with en_next = en & tc.
    assign tc = (up & (count == MAX)) | (~up & (count == '0));

endmodule : tff_updown_counter
